// File: rtl/segment_scan_driver.sv
`default_nettype none
// ============================================================================
// segment_scan_driver : multiplexed common-anode hex display scanner with a
// tear-free frame snapshot, PWM brightness, per-digit dp/blank, frame strobe.
// Optional macro SEGMENT_LZ_SUPPRESS_EN enables leading-zero suppression.
// Revision: 1.0
// ============================================================================
module segment_scan_driver #(
  parameter int DIGITS      = 8,
  parameter int CDIV        = 100000,
  parameter int BRIGHT_BITS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [4*DIGITS-1:0]    value,
  input  logic [DIGITS-1:0]      dp,
  input  logic [DIGITS-1:0]      blank,
  input  logic [BRIGHT_BITS-1:0] brightness,
  output logic [7:0]             cathodes,
  output logic [DIGITS-1:0]      anodes,
  output logic                   frame_done
);

  localparam int SW   = (CDIV > 1) ? $clog2(CDIV) : 1;
  localparam int DW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int STEP = CDIV / (2 ** BRIGHT_BITS);
  localparam logic [SW-1:0] SLOT_LAST = SW'(CDIV - 1);
  localparam logic [DW-1:0] DIG_LAST  = DW'(DIGITS - 1);

  logic [SW-1:0]       slot;
  logic [DW-1:0]       dig;
  logic [4*DIGITS-1:0] snap_value;
  logic [DIGITS-1:0]   snap_dp;
  logic [DIGITS-1:0]   snap_blank;
  logic [DIGITS-1:0]   suppress;
  logic [DIGITS-1:0]   anodes_next;
  logic                snap_edge;
  logic                snap_d;
  logic                lit;
  logic [3:0]          nib;
  logic [6:0]          seg;
  logic [31:0]         on_time;

  assign snap_edge = (slot == SLOT_LAST) && (dig == DIG_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot       <= '0;
      dig        <= '0;
      snap_value <= '0;
      snap_dp    <= '0;
      snap_blank <= '1;
    end else begin
      if (slot == SLOT_LAST) begin
        slot <= '0;
        dig  <= (dig == DIG_LAST) ? '0 : dig + 1'b1;
      end else begin
        slot <= slot + 1'b1;
      end
      if (snap_edge) begin
        snap_value <= value;
        snap_dp    <= dp;
        snap_blank <= blank;
      end
    end
  end

`ifdef SEGMENT_LZ_SUPPRESS_EN
  logic lz_run;

  // Walk down from the top digit; suppression ends at the first nonzero or dp digit.
  always_comb begin
    lz_run   = 1'b1;
    suppress = '0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      lz_run      = lz_run && (snap_value[4*i +: 4] == 4'h0) && !snap_dp[i];
      suppress[i] = lz_run;
    end
  end
`else
  assign suppress = '0;
`endif

  assign nib     = snap_value[{dig, 2'b00} +: 4];
  assign on_time = (32'(brightness) + 32'd1) * 32'(STEP);
  assign lit     = (32'(slot) < on_time) && !snap_blank[dig] && !suppress[dig];

  // Active-low gfedcba pattern of the current digit.
  always_comb begin
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
  end

  always_comb begin
    anodes_next = '1;
    for (int i = 0; i < DIGITS; i++) begin
      anodes_next[i] = !(lit && (dig == DW'(i)));
    end
  end

  // frame_done trails the snapshot edge by one cycle, aligned with digit 0's first output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      anodes     <= '1;
      cathodes   <= 8'hFF;
      snap_d     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      anodes     <= anodes_next;
      cathodes   <= lit ? {~snap_dp[dig], seg} : 8'hFF;
      snap_d     <= snap_edge;
      frame_done <= snap_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_segment_scan_driver.sv
`default_nettype none
// ============================================================================
// tb_segment_scan_driver : scoreboard bench for segment_scan_driver with
// DIGITS=4, CDIV=16, BRIGHT_BITS=2.
// Revision: 1.0
// ============================================================================
module tb_segment_scan_driver;

  localparam int DIGITS = 4;
  localparam int CDIV   = 16;
  localparam int FRAME  = DIGITS * CDIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value = '0;
  logic [3:0]  dp = '0;
  logic [3:0]  blank = '0;
  logic [1:0]  brightness = 2'd3;
  logic [7:0]  cathodes;
  logic [3:0]  anodes;
  logic        frame_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct packed {
    logic [3:0] an;
    logic [7:0] cat;
    logic       fd;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  segment_scan_driver #(.DIGITS(DIGITS), .CDIV(CDIV), .BRIGHT_BITS(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .value      (value),
    .dp         (dp),
    .blank      (blank),
    .brightness (brightness),
    .cathodes   (cathodes),
    .anodes     (anodes),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Scoreboard consumer: one expected entry per output cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      checks += 3;
      if (anodes !== mon_e.an) begin
        errors++;
        $display("FAIL scan_anodes cyc=%0d: got %h expected %h", cyc, anodes, mon_e.an);
      end
      if (cathodes !== mon_e.cat) begin
        errors++;
        $display("FAIL scan_cathodes cyc=%0d: got %h expected %h", cyc, cathodes, mon_e.cat);
      end
      if (frame_done !== mon_e.fd) begin
        errors++;
        $display("FAIL scan_frame_done cyc=%0d: got %b expected %b", cyc, frame_done, mon_e.fd);
      end
    end
  end

  // Expected outputs for one whole frame derived from the display rules.
  task automatic push_frame(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b,
                            input logic [1:0] br, input bit dark);
    logic [3:0] sup;
    exp_t e;
    sup = '0;
`ifdef SEGMENT_LZ_SUPPRESS_EN
    begin
      bit run;
      run = 1'b1;
      for (int k = 3; k > 0; k--) begin
        run    = run && (v[4*k +: 4] == 4'h0) && !d[k];
        sup[k] = run;
      end
    end
`endif
    for (int g = 0; g < DIGITS; g++) begin
      for (int s = 0; s < CDIV; s++) begin
        e.an  = 4'hF;
        e.cat = 8'hFF;
        e.fd  = !dark && (g == 0) && (s == 0);
        if (!dark && (s < (int'(br) + 1) * 4) && !b[g] && !sup[g]) begin
          e.an[g] = 1'b0;
          e.cat   = seg_tab[v[4*g +: 4]];
          if (d[g]) e.cat[7] = 1'b0;
        end
        sb.push_back(e);
      end
    end
  endtask

  task automatic drain(input int left);
    for (int i = 0; i < 3 * FRAME && sb.size() > left; i++) begin
      @(negedge clk);
      #1;
    end
    checks++;
    if (sb.size() > left) begin
      errors++;
      $display("FAIL drain_timeout: got %0d entries pending expected %0d", sb.size(), left);
      sb.delete();
    end
  endtask

  // Return just after the posedge that produces the first output of a frame.
  task automatic sync_frame();
    @(posedge clk);
    #1;
    while (cyc % FRAME != 1) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks += 3;
    if (anodes !== 4'hF) begin errors++; $display("FAIL reset_anodes: got %h expected f", anodes); end
    if (cathodes !== 8'hFF) begin errors++; $display("FAIL reset_cathodes: got %h expected ff", cathodes); end
    if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
    #1 rst = 1'b0;
    push_frame(16'h0, 4'h0, 4'hF, brightness, 1'b1);
    drain(1);
  endtask

  task automatic test_scan_decode();
    value = 16'hF810; dp = 4'h0; blank = 4'h0; brightness = 2'd3;
    sync_frame();
    push_frame(value, dp, blank, brightness, 1'b0);
    drain(0);
  endtask

  task automatic test_brightness();
    brightness = 2'd0;
    sync_frame();
    push_frame(value, dp, blank, brightness, 1'b0);
    drain(0);
    brightness = 2'd2;
    sync_frame();
    push_frame(value, dp, blank, brightness, 1'b0);
    drain(1);
  endtask

  task automatic test_snapshot();
    value = 16'h1111;
    sync_frame();
    push_frame(16'h1111, dp, blank, brightness, 1'b0);
    repeat (20) @(negedge clk);
    value = 16'h2222;
    drain(1);
    sync_frame();
    push_frame(16'h2222, dp, blank, brightness, 1'b0);
    drain(1);
    value = 16'h3333;
    sync_frame();
    value = 16'h4444;
    push_frame(16'h3333, dp, blank, brightness, 1'b0);
    drain(1);
    sync_frame();
    push_frame(16'h4444, dp, blank, brightness, 1'b0);
    drain(1);
  endtask

  task automatic test_dp_blank();
    value = 16'hF810; dp = 4'b0010; blank = 4'b1000;
    sync_frame();
    push_frame(value, dp, blank, brightness, 1'b0);
    drain(1);
  endtask

  task automatic test_leading_zero();
    value = 16'h0040; dp = 4'b0000; blank = 4'b0000;
    sync_frame();
    push_frame(value, dp, blank, brightness, 1'b0);
    drain(1);
    dp = 4'b1000;
    sync_frame();
    push_frame(value, dp, blank, brightness, 1'b0);
    drain(1);
  endtask

  task automatic test_reset_mid_frame();
    value = 16'hF810; dp = 4'b0000; blank = 4'b0000;
    sync_frame();
    for (int i = 0; i < 2 * FRAME && (cyc % FRAME) != 40; i++) begin
      @(negedge clk);
      #1;
    end
    checks += 2;
    if (anodes !== 4'hB) begin errors++; $display("FAIL midreset_lit_anodes: got %h expected b", anodes); end
    if (cathodes !== 8'h80) begin errors++; $display("FAIL midreset_lit_cathodes: got %h expected 80", cathodes); end
    #2 rst = 1'b1;
    #1;
    checks += 3;
    if (anodes !== 4'hF) begin errors++; $display("FAIL midreset_anodes: got %h expected f", anodes); end
    if (cathodes !== 8'hFF) begin errors++; $display("FAIL midreset_cathodes: got %h expected ff", cathodes); end
    if (frame_done !== 1'b0) begin errors++; $display("FAIL midreset_frame_done: got %b expected 0", frame_done); end
    @(negedge clk);
    #1 rst = 1'b0;
    push_frame(16'h0, 4'h0, 4'hF, brightness, 1'b1);
    drain(1);
    sync_frame();
    push_frame(value, dp, blank, brightness, 1'b0);
    drain(0);
  endtask

  initial begin
    test_reset();
    test_scan_decode();
    test_brightness();
    test_snapshot();
    test_dp_blank();
    test_leading_zero();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
